matrix_elem_loader: RTL and testbench

MATRIX_ELEM_LOADER -- requirements
Module: matrix_elem_loader

---
 rtl/matrix_elem_loader_pkg.sv | 22 ++
 rtl/matrix_elem_loader_elem_addr_decoder.sv | 26 ++
 rtl/matrix_elem_loader.sv | 131 +++++++++++++
 tb/tb_matrix_elem_loader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/matrix_elem_loader_pkg.sv
// Shared types and helpers for the matrix element loader.
package matrix_elem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Flat element index: row-major, bit index of the one-hot write enable.
  function automatic int unsigned idx(input int unsigned row,
                                      input int unsigned col,
                                      input int unsigned cols);
    return row * cols + col;
  endfunction

  // Address field width, never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_elem_loader_elem_addr_decoder.sv
// Combinational {row, col} to one-hot element decoder with enable and range flag.
module elem_addr_decoder
  import matrix_elem_loader_pkg::*;
#(
  parameter int unsigned ROWS   = 3,
  parameter int unsigned COLS   = 3,
  parameter int unsigned ROW_AW = 2,
  parameter int unsigned COL_AW = 2,
  parameter int unsigned NEL    = ROWS * COLS
) (
  input  logic              en,
  input  logic [ROW_AW-1:0] row,
  input  logic [COL_AW-1:0] col,
  output logic [NEL-1:0]    onehot,
  output logic              in_range
);

  always_comb begin
    onehot   = '0;
    in_range = (32'(row) < ROWS) && (32'(col) < COLS);
    for (int unsigned i = 0; i < NEL; i++) begin
      onehot[i] = en && in_range && (idx(32'(row), 32'(col), COLS) == i);
    end
  end

endmodule

// File: rtl/matrix_elem_loader.sv
// Loads matrix elements as one-hot write strobes, either by random address or
// as a row-major stream started by a pulse on start.
module matrix_elem_loader
  import matrix_elem_loader_pkg::*;
#(
  parameter int unsigned ROWS   = 3,
  parameter int unsigned COLS   = 3,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned ROW_AW = addr_w(ROWS),
  localparam int unsigned COL_AW = addr_w(COLS),
  localparam int unsigned ADDR_W = ROW_AW + COL_AW,
  localparam int unsigned NEL    = ROWS * COLS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic [NEL-1:0]    we,
  output logic [DATA_W-1:0] wdata,
  output logic              err,
  output logic              done,
  output logic              busy
);

  state_e              state;
  logic [ROW_AW-1:0]   row_cnt;
  logic [COL_AW-1:0]   col_cnt;
  logic                accept;
  logic                last_elem;
  logic [ROW_AW-1:0]   sel_row;
  logic [COL_AW-1:0]   sel_col;
  logic [NEL-1:0]      dec_onehot;
  logic                dec_in_range;

  // in_ready is a register tracking state, so acceptance has no path from in_valid to in_ready.
  assign accept    = in_valid & in_ready;
  assign last_elem = (row_cnt == ROW_AW'(ROWS - 1)) && (col_cnt == COL_AW'(COLS - 1));

  // Stream mode writes at the counters; otherwise the beat carries its own address.
  always_comb begin
    sel_row = in_addr[ADDR_W-1:COL_AW];
    sel_col = in_addr[COL_AW-1:0];
    if (state == ST_STREAM) begin
      sel_row = row_cnt;
      sel_col = col_cnt;
    end
  end

  elem_addr_decoder #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .ROW_AW (ROW_AW),
    .COL_AW (COL_AW),
    .NEL    (NEL)
  ) u_dec (
    .en       (accept),
    .row      (sel_row),
    .col      (sel_col),
    .onehot   (dec_onehot),
    .in_range (dec_in_range)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      row_cnt  <= '0;
      col_cnt  <= '0;
      we       <= '0;
      wdata    <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      we   <= dec_onehot;
      err  <= accept && !dec_in_range;
      done <= 1'b0;
      if (accept && dec_in_range) begin
        wdata <= in_data;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_STREAM;
            row_cnt <= '0;
            col_cnt <= '0;
            busy    <= 1'b1;
          end
        end

        ST_STREAM: begin
          if (accept) begin
            if (col_cnt == COL_AW'(COLS - 1)) begin
              col_cnt <= '0;
              row_cnt <= last_elem ? '0 : row_cnt + ROW_AW'(1);
            end else begin
              col_cnt <= col_cnt + COL_AW'(1);
            end
          end
          // Abort wins over completion: the final beat is still written, but no done.
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (accept && last_elem) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            in_ready <= 1'b0;
          end
        end

        ST_DONE: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end

        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_elem_loader.sv
// Self-checking bench for matrix_elem_loader against a cycle-level behavioural model.
module tb_matrix_elem_loader;

  localparam int unsigned ROWS = 3;
  localparam int unsigned COLS = 3;
  localparam int unsigned DW   = 8;
  localparam int unsigned NEL  = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_addr;
  logic [DW-1:0] in_data;
  logic [NEL-1:0] we;
  logic [DW-1:0] wdata;
  logic          err;
  logic          done;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: streaming flag, next stream element position, done-cycle flag, last written data.
  bit            m_stream;
  bit            m_in_done;
  int            m_pos;
  logic [DW-1:0] m_wdata;

  matrix_elem_loader #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .we       (we),
    .wdata    (wdata),
    .err      (err),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stream  = 0;
    m_in_done = 0;
    m_pos     = 0;
    m_wdata   = '0;
  endtask

  // Drive one cycle of inputs, predict outputs, clock, and compare.
  task automatic step(input logic st, input logic ab, input logic v,
                      input logic [3:0] a, input logic [DW-1:0] d);
    logic [NEL-1:0] ewe;
    logic eerr, edone;
    bit acc;
    int r, c;
    start = st; abort = ab; in_valid = v; in_addr = a; in_data = d;
    chk("in_ready", 32'(in_ready), 32'(!m_in_done));
    ewe = '0; eerr = 0; edone = 0;
    acc = v && !m_in_done;
    if (m_in_done) begin
      m_in_done = 0;
    end else if (m_stream) begin
      if (acc) begin
        ewe[m_pos] = 1'b1;
        m_wdata    = d;
        m_pos++;
      end
      if (ab) m_stream = 0;
      else if (m_pos == NEL) begin
        m_stream  = 0;
        m_in_done = 1;
        edone     = 1;
      end
    end else begin
      if (acc) begin
        r = int'(a[3:2]);
        c = int'(a[1:0]);
        if (r < ROWS && c < COLS) begin
          ewe[r * COLS + c] = 1'b1;
          m_wdata = d;
        end else eerr = 1;
      end
      if (st) begin
        m_stream = 1;
        m_pos    = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("we",    32'(we),    32'(ewe));
    chk("wdata", 32'(wdata), 32'(m_wdata));
    chk("err",   32'(err),   32'(eerr));
    chk("done",  32'(done),  32'(edone));
    chk("busy",  32'(busy),  32'(m_stream || m_in_done));
    start = 0; abort = 0; in_valid = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    32'(we),    32'(0));
    chk({tag, "_wdata"}, 32'(wdata), 32'(0));
    chk({tag, "_err"},   32'(err),   32'(0));
    chk({tag, "_done"},  32'(done),  32'(0));
    chk({tag, "_busy"},  32'(busy),  32'(0));
  endtask

  initial begin
    rst = 1'b1; start = 0; abort = 0; in_valid = 0; in_addr = '0; in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    rst = 1'b0;

    // Random write in range, then both out-of-range forms.
    step(0, 0, 1, 4'b0110, 8'hA5);
    chk("rand_we_literal", 32'(we), 32'(9'b000100000));
    step(0, 0, 1, 4'b1011, 8'h3C);
    chk("rand_col_err", 32'(err), 32'(1));
    step(0, 0, 0, 4'b0000, 8'h00);
    chk("err_one_cycle", 32'(err), 32'(0));
    step(0, 0, 1, 4'b1100, 8'h77);
    chk("rand_row_err", 32'(err), 32'(1));
    chk("wdata_hold", 32'(wdata), 32'(8'hA5));

    // Full back-to-back stream; beat in the start cycle is a random write.
    step(1, 0, 1, 4'b0000, 8'h55);
    for (int i = 1; i <= 9; i++) step(0, 0, 1, 4'($urandom), 8'(i));
    chk("stream_done", 32'(done), 32'(1));
    chk("stream_last_we", 32'(we), 32'(9'h100));
    step(1, 0, 1, 4'b0000, 8'hEE);
    step(0, 0, 0, 4'b0000, 8'h00);

    // Stream with random gaps in in_valid.
    step(1, 0, 0, 4'b0000, 8'h00);
    while (m_stream) step(0, 0, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
    step(0, 0, 0, 4'b0000, 8'h00);

    // Four beats then abort; restart from element 0.
    step(1, 0, 0, 4'b0000, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 4'($urandom), 8'(8'h10 + i));
    step(0, 1, 0, 4'b0000, 8'h00);
    chk("abort_busy", 32'(busy), 32'(0));
    step(0, 1, 1, 4'b0001, 8'h21);
    step(1, 0, 0, 4'b0000, 8'h00);
    step(0, 0, 1, 4'b1111, 8'h30);
    chk("restart_bit0", 32'(we), 32'(9'h001));
    while (m_stream) step(0, 0, 1, 4'($urandom), 8'($urandom));
    step(0, 0, 0, 4'b0000, 8'h00);

    // Asynchronous reset mid-stream, then a clean full stream.
    step(1, 0, 0, 4'b0000, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 4'($urandom), 8'(8'h40 + i));
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 0, 0, 4'b0000, 8'h00);
    step(0, 0, 1, 4'b0000, 8'h61);
    chk("post_rst_bit0", 32'(we), 32'(9'h001));
    for (int i = 1; i < 9; i++) step(0, 0, 1, 4'($urandom), 8'(8'h61 + i));
    chk("post_rst_done", 32'(done), 32'(1));
    step(0, 0, 0, 4'b0000, 8'h00);

    // Randomized soak over all inputs.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 3) != 0), 4'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
